// File: rtl/booth_seq_multiplier_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier.
//   WIDTH_DEF : default operand width
//   ST_*      : FSM state encoding (IDLE/RUN/DONE), also exposed on the debug port
//   SEG_*     : 3-bit Booth segment codes {b[2i+1], b[2i], b[2i-1]}
package booth_seq_multiplier_pkg;

  localparam int WIDTH_DEF = 26;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // Booth segment codes and the partial product each selects
  localparam logic [2:0] SEG_Z0  = 3'b000;  // 0
  localparam logic [2:0] SEG_P1A = 3'b001;  // +A
  localparam logic [2:0] SEG_P1B = 3'b010;  // +A
  localparam logic [2:0] SEG_P2  = 3'b011;  // +2A
  localparam logic [2:0] SEG_M2  = 3'b100;  // -2A
  localparam logic [2:0] SEG_M1A = 3'b101;  // -A
  localparam logic [2:0] SEG_M1B = 3'b110;  // -A
  localparam logic [2:0] SEG_Z1  = 3'b111;  // 0

endpackage

// File: rtl/booth_seq_multiplier_pp_select.sv
// Combinational radix-4 Booth partial-product selector.
//   A   in  WIDTH    signed multiplicand
//   seg in  3        Booth segment {b[2i+1], b[2i], b[2i-1]}
//   pp  out 2*WIDTH  signed partial product (0, +-A, +-2A), sign-extended
module booth_pp_select
  import booth_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0]   A,
  input  logic [2:0]         seg,
  output logic [2*WIDTH-1:0] pp
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] a_ext_x2;

  // Working at full product width keeps +-2A of the most negative A exact.
  assign a_ext    = {{WIDTH{A[WIDTH-1]}}, A};
  assign a_ext_x2 = {a_ext[2*WIDTH-2:0], 1'b0};

  always_comb begin
    pp = '0;
    case (seg)
      SEG_Z0, SEG_Z1:   pp = '0;
      SEG_P1A, SEG_P1B: pp = a_ext;
      SEG_P2:           pp = a_ext_x2;
      SEG_M2:           pp = ~a_ext_x2 + 1'b1;
      SEG_M1A, SEG_M1B: pp = ~a_ext + 1'b1;
      default:          pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-4 Booth multiplier: one Booth segment per RUN cycle,
// WIDTH/2 RUN cycles per product, exact 2*WIDTH signed result.
//   clk, rst      clock, synchronous active-high reset
//   in_valid      operand pair valid          in_ready  accepts (IDLE only)
//   multiplicand  signed A                    multiplier signed B
//   out_valid     product valid (held)        out_ready downstream accepts
//   product       signed A*B (zero unless out_valid)
//   busy          high in RUN or DONE         dbg_state FSM state (ST_* encoding)
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds data and valid stable until that edge. Input side
// accepts only in IDLE, output side completes only in DONE; there is no bypass
// from DONE straight into a new operation.
module booth_seq_multiplier
  import booth_seq_multiplier_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  localparam int NSEG  = WIDTH / 2;
  localparam int SEG_W = (NSEG > 1) ? $clog2(NSEG) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH:0]     sreg_q, sreg_d;      // {B, 1'b0}, shifted right 2 per segment
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [SEG_W-1:0]   seg_idx_q, seg_idx_d;

  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] pp_shifted;
  logic               last_seg;

  booth_pp_select #(.WIDTH(WIDTH)) u_pp_select (
    .A   (a_q),
    .seg (sreg_q[2:0]),
    .pp  (pp)
  );

  // Weight of segment i is 4^i; carries past 2*WIDTH are dropped, which is
  // exact because the true product always fits in 2*WIDTH signed bits.
  assign pp_shifted = pp << {seg_idx_q, 1'b0};
  assign last_seg   = (seg_idx_q == SEG_W'(NSEG - 1));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    sreg_d    = sreg_q;
    acc_d     = acc_q;
    seg_idx_d = seg_idx_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d       = multiplicand;
          sreg_d    = {multiplier, 1'b0};
          acc_d     = '0;
          seg_idx_d = '0;
          state_d   = S_RUN;
        end
      end
      S_RUN: begin
        acc_d     = acc_q + pp_shifted;
        sreg_d    = {{2{sreg_q[WIDTH]}}, sreg_q[WIDTH:2]};
        seg_idx_d = seg_idx_q + SEG_W'(1);
        if (last_seg) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      sreg_q    <= '0;
      acc_q     <= '0;
      seg_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      sreg_q    <= sreg_d;
      acc_q     <= acc_d;
      seg_idx_q <= seg_idx_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
  // Partial sums are not shown outside DONE.
  assign product   = out_valid ? acc_q : '0;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
module tb_booth_seq_multiplier;
  import booth_seq_multiplier_pkg::*;

  localparam int W    = 26;
  localparam int NSEG = W / 2;
  localparam int LAT  = NSEG + 1;   // negedges from accept edge to out_valid seen

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;
  logic [1:0]     dbg_state;

  always #5 clk = ~clk;

  booth_seq_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product),
    .busy         (busy),
    .dbg_state    (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return (2*W)'(sa * sb);
  endfunction

  function automatic logic [W-1:0] rand_operand();
    logic [W-1:0] corners [5];
    corners[0] = 26'h2000000;
    corners[1] = 26'h1FFFFFF;
    corners[2] = 26'h0000000;
    corners[3] = 26'h3FFFFFF;
    corners[4] = 26'h0000001;
    if ($urandom_range(0, 7) == 0) return corners[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    multiplicand = '0; multiplier = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge; returns just after the accepting rising edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    int n;
    n = 0;
    in_valid = 1'b1; multiplicand = a; multiplier = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
  endtask

  // Counts negedges until out_valid while scrambling inputs that must be ignored.
  task automatic wait_done(output int lat, output int ready_seen);
    lat = 0; ready_seen = 0;
    do begin
      @(negedge clk);
      lat++;
      if (in_ready) ready_seen++;
      if (!out_valid) begin
        in_valid     = 1'($urandom_range(0, 1));
        multiplicand = W'($urandom);
        multiplier   = W'($urandom);
        out_ready    = 1'($urandom_range(0, 1));
      end
    end while (!out_valid && lat < 64);
    if (!out_valid) lat = -1;
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 ||
        product !== '0 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL reset: in_ready=%b out_valid=%b busy=%b product=%h state=%0d, need 1 0 0 0 %0d",
               in_ready, out_valid, busy, product, dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [5];
    logic [W-1:0] tb [5];
    logic [2*W-1:0] exp_p;
    int lat, rs;
    ta[0] = 26'd3;       tb[0] = 26'd5;
    ta[1] = 26'h3FFFFFF; tb[1] = 26'h3FFFFFF;
    ta[2] = 26'h2000000; tb[2] = 26'h2000000;
    ta[3] = 26'h2000000; tb[3] = 26'h1FFFFFF;
    ta[4] = 26'h1555555; tb[4] = 26'h2AAAAAA;
    for (int i = 0; i < 5; i++) begin
      start_op(ta[i], tb[i]);
      wait_done(lat, rs);
      exp_p = ref_mul(ta[i], tb[i]);
      n_vec++;
      if (lat !== LAT || rs !== 0) begin
        n_err++;
        $display("FAIL directed_latency[%0d]: latency=%0d in_ready_high=%0d, need %0d and 0", i, lat, rs, LAT);
      end
      n_vec++;
      if (product !== exp_p) begin
        n_err++;
        $display("FAIL directed_product[%0d]: got %h, need %h", i, product, exp_p);
      end
      consume();
    end
    // spot-check the model against the hand-derived corner results
    n_vec++;
    if (ref_mul(26'h2000000, 26'h2000000) !== 52'h4_0000_0000_0000) begin
      n_err++;
      $display("FAIL model_min_sq: got %h, need %h", ref_mul(26'h2000000, 26'h2000000), 52'h4_0000_0000_0000);
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] a, b, c, d;
    logic [2*W-1:0] exp1;
    int lat, rs;
    a = 26'h0ABCDEF; b = 26'h3F01234; c = 26'h2345678; d = 26'h1000003;
    exp1 = ref_mul(a, b);
    start_op(a, b);
    wait_done(lat, rs);
    in_valid = 1'b1; multiplicand = c; multiplier = d; out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || product !== exp1 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: out_valid=%b product=%h in_ready=%b, need 1 %h 0",
                 k, out_valid, product, in_ready, exp1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || dbg_state !== ST_IDLE) begin
      n_err++;
      $display("FAIL bp_no_bypass: out_valid=%b in_ready=%b state=%0d, need 0 1 %0d",
               out_valid, in_ready, dbg_state, ST_IDLE);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || dbg_state !== ST_RUN) begin
      n_err++;
      $display("FAIL bp_accept_next: busy=%b state=%0d, need 1 %0d", busy, dbg_state, ST_RUN);
    end
    wait_done(lat, rs);
    n_vec++;
    if (lat !== LAT - 1 || product !== ref_mul(c, d)) begin
      n_err++;
      $display("FAIL bp_second_op: latency=%0d product=%h, need %0d %h", lat, product, LAT - 1, ref_mul(c, d));
    end
    consume();
  endtask

  task automatic test_reset_mid_op();
    int lat, rs;
    int ov_seen;
    start_op(26'h1234567, 26'h0765432);
    in_valid = 1'b0;
    ov_seen = 0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if (dbg_state !== ST_IDLE || out_valid !== 1'b0 || product !== '0 ||
        busy !== 1'b0 || in_ready !== 1'b1 || ov_seen !== 0) begin
      n_err++;
      $display("FAIL reset_mid_run: state=%0d out_valid=%b product=%h busy=%b in_ready=%b ov_seen=%0d, need %0d 0 0 0 1 0",
               dbg_state, out_valid, product, busy, in_ready, ov_seen, ST_IDLE);
    end
    start_op(26'd7, 26'h3FFFFFD);
    wait_done(lat, rs);
    n_vec++;
    if (lat !== LAT || product !== 52'hF_FFFF_FFFF_FFEB) begin
      n_err++;
      $display("FAIL after_reset_7x-3: latency=%0d product=%h, need %0d %h", lat, product, LAT, 52'hF_FFFF_FFFF_FFEB);
    end
    consume();
  endtask

  task automatic test_random(input int n_ops);
    logic [W-1:0] a, b;
    logic [2*W-1:0] exp_q [$];
    logic [2*W-1:0] exp_p;
    int lat, rs, bp;
    for (int i = 0; i < n_ops; i++) begin
      a = rand_operand();
      b = rand_operand();
      exp_q.push_back(ref_mul(a, b));
      start_op(a, b);
      wait_done(lat, rs);
      exp_p = exp_q.pop_front();
      n_vec++;
      if (lat !== LAT || rs !== 0 || product !== exp_p) begin
        n_err++;
        $display("FAIL random[%0d] a=%h b=%h: latency=%0d in_ready_high=%0d product=%h, need %0d 0 %h",
                 i, a, b, lat, rs, product, LAT, exp_p);
      end
      bp = $urandom_range(0, 3);
      for (int k = 0; k < bp; k++) begin
        in_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b1 || product !== exp_p) begin
          n_err++;
          $display("FAIL random_hold[%0d]: out_valid=%b product=%h, need 1 %h", i, out_valid, product, exp_p);
        end
      end
      in_valid = 1'b0;
      consume();
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid_op();
    test_random(2000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
